// File: rtl/class_arbiter_pkg.sv
// Shared transaction-layer definitions: word width, class count, class
// encodings and the round-robin pick used by the class merge.
package pcie_tl_pkg;

  localparam int DATA_W    = 12;
  localparam int NUM_CLASS = 4;

  typedef enum logic [1:0] {
    CLASS0 = 2'b00,
    CLASS1 = 2'b01,
    CLASS2 = 2'b10,
    CLASS3 = 2'b11
  } tclass_e;

  // First requesting class after 'last', wrapping; returns 'last' if none.
  function automatic logic [1:0] rr_pick(input logic [NUM_CLASS-1:0] req,
                                         input logic [1:0]           last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CLASS; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/class_arbiter_if.sv
// Per-class inputs from the demux and the merged output stream.
interface class_arbiter_if #(parameter int DATA_W = 12);
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              valid_in0, valid_in1, valid_in2, valid_in3;
  logic              ready_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [3:0]        fifo_full;
  logic [3:0]        fifo_empty;
  logic [3:0]        overflow;

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output ready_out,
    input  data_out, valid_out, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  ready_out,
    output data_out, valid_out, fifo_full, fifo_empty, overflow
  );
endinterface

// File: rtl/class_arbiter_fifo.sv
// Single-class FIFO. Head is read combinationally; the caller only pops
// when non-empty and only pushes when there is room (or a pop the same cycle).
module class_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/class_arbiter.sv
// Buffers the four traffic classes in their own FIFOs and merges them onto
// one registered output stream with a round-robin grant under valid/ready.
module class_arbiter
  import pcie_tl_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic            clk,
  input  logic            reset_L,
  class_arbiter_if.slave  bus
);

  logic [NUM_CLASS-1:0][DATA_W-1:0] din, head;
  logic [NUM_CLASS-1:0][PTR_W:0]    count;
  logic [NUM_CLASS-1:0]             vin, push, pop, full, empty;

  logic [1:0]        last_grant, gnt;
  logic              load, any_req;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [NUM_CLASS-1:0] ovf_q;

  assign din = {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0};
  assign vin = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};

  // Output register refills whenever it is empty or being consumed.
  assign load    = !valid_q || bus.ready_out;
  assign any_req = |(~empty);
  assign gnt     = rr_pick(~empty, last_grant);

  for (genvar g = 0; g < NUM_CLASS; g++) begin : gen_class
    assign pop[g]  = load && any_req && (gnt == 2'(g));
    // A full FIFO still accepts a word when its head leaves the same cycle.
    assign push[g] = vin[g] && ((count[g] < (PTR_W+1)'(DEPTH)) || pop[g]);

    class_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk     (clk),
      .reset_L (reset_L),
      .push    (push[g]),
      .pop     (pop[g]),
      .wr_data (din[g]),
      .rd_data (head[g]),
      .count   (count[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  // Output register and grant pointer; data_out holds its value when idle.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_grant <= CLASS3;
    end else if (load) begin
      if (any_req) begin
        data_q     <= head[gnt];
        valid_q    <= 1'b1;
        last_grant <= gnt;
      end else begin
        valid_q    <= 1'b0;
      end
    end
  end

  // Sticky drop flags: a valid word that could not be pushed was lost.
  always_ff @(posedge clk) begin
    if (!reset_L) ovf_q <= '0;
    else          ovf_q <= ovf_q | (vin & ~push);
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_class_arbiter.sv
// Scoreboard bench for class_arbiter: expected words are queued in the order
// the arbiter must emit them and compared as each handshake completes.
module tb_class_arbiter;

  logic clk = 1'b0;
  logic reset_L;

  class_arbiter_if #(.DATA_W(12)) ifc ();

  class_arbiter #(.DATA_W(12), .DEPTH(4), .PTR_W(2)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input int c, input int n);
    logic [1:0] cb;
    logic [9:0] pl;
    cb = 2'(c);
    pl = 10'(n * 7 + c * 64 + 1);
    return {cb, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c, input logic [11:0] d, input logic v);
    case (c)
      0: begin ifc.data_in0 = d; ifc.valid_in0 = v; end
      1: begin ifc.data_in1 = d; ifc.valid_in1 = v; end
      2: begin ifc.data_in2 = d; ifc.valid_in2 = v; end
      default: begin ifc.data_in3 = d; ifc.valid_in3 = v; end
    endcase
  endtask

  task automatic clear_in();
    for (int c = 0; c < 4; c++) set_in(c, 12'h000, 1'b0);
  endtask

  task automatic do_reset();
    clear_in();
    ifc.ready_out = 1'b0;
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    sb.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    ifc.ready_out = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk(tag, sb.size(), 0);
  endtask

  // Every completed handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && ifc.valid_out === 1'b1 && ifc.ready_out === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected", {20'h0, ifc.data_out}, 32'hFFFF_FFFF);
      else chk("sb_data", {20'h0, ifc.data_out}, {20'h0, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    ifc.ready_out = 1'b0;
    reset_L = 1'b0;
    repeat (3) tick();
    reset_L = 1'b1;
    tick();

    // 1: idle after reset
    chk("rst_valid", ifc.valid_out, 0);
    chk("rst_empty", ifc.fifo_empty, 4'hF);
    chk("rst_full", ifc.fifo_full, 4'h0);
    chk("rst_ovf", ifc.overflow, 4'h0);
    chk("rst_data", ifc.data_out, 12'h000);

    // 2: single word fall-through latency
    ifc.ready_out = 1'b1;
    set_in(2, 12'h8A5, 1'b1);
    sb.push_back(12'h8A5);
    tick();
    set_in(2, 12'h000, 1'b0);
    chk("lat_v_t", ifc.valid_out, 0);
    chk("lat_empty_t", ifc.fifo_empty, 4'hB);
    tick();
    chk("lat_v_t1", ifc.valid_out, 1);
    chk("lat_d_t1", ifc.data_out, 12'h8A5);
    chk("lat_empty_t1", ifc.fifo_empty, 4'hF);
    tick();
    chk("lat_v_t2", ifc.valid_out, 0);
    chk("lat_sb", sb.size(), 0);

    // 3: two words per class, round-robin order 0,1,2,3,0,1,2,3
    do_reset();
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 4; c++) set_in(c, mk(c, n), 1'b1);
      tick();
    end
    clear_in();
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < 4; c++) sb.push_back(mk(c, n));
    drain("rr_drain");
    chk("rr_empty", ifc.fifo_empty, 4'hF);

    // 4: class 1 overflow (first word lands in the output register)
    do_reset();
    for (int n = 0; n < 6; n++) begin
      set_in(1, mk(1, n), 1'b1);
      if (n < 5) sb.push_back(mk(1, n));
      tick();
      if (n == 4) begin
        chk("ovf_full", ifc.fifo_full, 4'b0010);
        chk("ovf_none_yet", ifc.overflow, 4'h0);
      end
    end
    clear_in();
    chk("ovf_set", ifc.overflow, 4'b0010);
    drain("ovf_drain");
    chk("ovf_sticky", ifc.overflow, 4'b0010);

    // 5: full class 0 streaming at one word per cycle
    do_reset();
    for (int n = 0; n < 5; n++) begin
      set_in(0, mk(0, n), 1'b1);
      sb.push_back(mk(0, n));
      tick();
    end
    chk("thr_full", ifc.fifo_full, 4'b0001);
    ifc.ready_out = 1'b1;
    for (int n = 5; n < 13; n++) begin
      set_in(0, mk(0, n), 1'b1);
      sb.push_back(mk(0, n));
      tick();
      chk("thr_valid", ifc.valid_out, 1);
    end
    clear_in();
    drain("thr_drain");
    chk("thr_ovf", ifc.overflow, 4'h0);

    // 6: stall holds data_out; reset mid-stall discards everything
    do_reset();
    set_in(3, 12'hC3C, 1'b1);
    tick();
    set_in(3, 12'h000, 1'b0);
    set_in(2, mk(2, 1), 1'b1);
    tick();
    clear_in();
    for (int n = 0; n < 3; n++) begin
      chk("stall_valid", ifc.valid_out, 1);
      chk("stall_data", ifc.data_out, 12'hC3C);
      tick();
    end
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    sb.delete();
    chk("mrst_valid", ifc.valid_out, 0);
    chk("mrst_empty", ifc.fifo_empty, 4'hF);
    chk("mrst_data", ifc.data_out, 12'h000);
    ifc.ready_out = 1'b1;
    tick();
    chk("mrst_idle", ifc.valid_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
